bnn_layer_engine: RTL and testbench

- Parametrised single-layer binary (XNOR-popcount) neuron engine; successor to the hard-wired two-layer compute sequencer.
- Processes one fully-connected layer per start command. A top-level controller issues one command per layer.
- Reads WORD-bit activation and weight words from banked synchronous memories and accumulates XNOR matches per neuron.
- Thresholds each neuron's sum and packs the output bits into WORD-bit words, which it writes back to a selectable activation bank.

---
 rtl/bnn_layer_engine.sv | 165 ++++++++++++++++
 tb/tb_bnn_layer_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_engine.sv
// Single fully-connected binary layer: XNOR-popcount per neuron over banked word memories,
// threshold each neuron, pack WORD neuron bits per output word and write back.
module bnn_layer_engine #(
  parameter int WORD       = 8,
  parameter int W_ADDR_LEN = 20,
  parameter int W_SEL_LEN  = 2,
  parameter int X_ADDR_LEN = 10,
  parameter int X_SEL_LEN  = 2,
  parameter int ACC_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [X_ADDR_LEN-1:0] in_words,
  input  logic [X_ADDR_LEN-1:0] n_out,
  input  logic [ACC_W-1:0]      thresh,
  input  logic [X_SEL_LEN-1:0]  src_sel,
  input  logic [X_SEL_LEN-1:0]  dst_sel,
  input  logic [W_SEL_LEN-1:0]  wbank,
  output logic                  busy,
  output logic                  done,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic [W_SEL_LEN-1:0]  w_sel,
  input  logic [WORD-1:0]       w_data,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [X_SEL_LEN-1:0]  x_sel,
  input  logic [WORD-1:0]       x_rdata,
  output logic [WORD-1:0]       x_wdata,
  output logic                  x_we,
  output logic [2:0]            dbg_state
);

  localparam int LOGW = $clog2(WORD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [X_ADDR_LEN-1:0] iw_q, nout_q, k_q, j_q;
  logic [ACC_W-1:0]      thresh_q, acc_q;
  logic [X_SEL_LEN-1:0]  src_q, dst_q;
  logic [W_SEL_LEN-1:0]  wbank_q;
  logic [W_ADDR_LEN-1:0] w_addr_q;
  logic [WORD-1:0]       pack_q;
  logic                  rd_valid_q;

  logic                  last_word, last_neuron, word_full, degenerate;
  logic [WORD-1:0]       xnor_w;
  logic [ACC_W-1:0]      match_cnt, acc_sum;
  logic                  neuron_bit;

  assign last_word   = (k_q == iw_q - 1'b1);
  assign last_neuron = (j_q == nout_q - 1'b1);
  assign word_full   = (j_q[LOGW-1:0] == LOGW'(WORD - 1));
  assign degenerate  = (in_words == '0) || (n_out == '0);

  // Read data lags its issue by one cycle, so rd_valid_q marks cycles carrying a word to absorb.
  always_comb begin
    xnor_w    = ~(x_rdata ^ w_data);
    match_cnt = '0;
    for (int i = 0; i < WORD; i++) begin
      match_cnt = match_cnt + ACC_W'(xnor_w[i]);
    end
    acc_sum    = acc_q + (rd_valid_q ? match_cnt : '0);
    neuron_bit = (acc_sum >= thresh_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = degenerate ? S_DONE : S_RUN;
      S_RUN:   if (last_word) state_d = S_ACC;
      S_ACC:   state_d = (word_full || last_neuron) ? S_WRITE : S_RUN;
      S_WRITE: state_d = last_neuron ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    x_we      = (state_q == S_WRITE);
    x_addr    = (state_q == S_WRITE) ? X_ADDR_LEN'(j_q >> LOGW) : k_q;
    x_sel     = (state_q == S_WRITE) ? dst_q : src_q;
    x_wdata   = pack_q;
    w_addr    = w_addr_q;
    w_sel     = wbank_q;
    dbg_state = state_q;
  end

  // w_addr_q advances only when another issue follows, so it holds the last issued address outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iw_q       <= '0;
      nout_q     <= '0;
      thresh_q   <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      wbank_q    <= '0;
      k_q        <= '0;
      j_q        <= '0;
      w_addr_q   <= '0;
      acc_q      <= '0;
      pack_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == S_RUN);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            iw_q     <= in_words;
            nout_q   <= n_out;
            thresh_q <= thresh;
            src_q    <= src_sel;
            dst_q    <= dst_sel;
            wbank_q  <= wbank;
            k_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            pack_q   <= '0;
            if (!degenerate) w_addr_q <= '0;
          end
        end
        S_RUN: begin
          acc_q <= acc_sum;
          if (last_word) begin
            k_q <= '0;
          end else begin
            k_q      <= k_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        S_ACC: begin
          acc_q                  <= '0;
          pack_q[j_q[LOGW-1:0]] <= neuron_bit;
          if (!(word_full || last_neuron)) begin
            j_q      <= j_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        S_WRITE: begin
          pack_q <= '0;
          if (!last_neuron) begin
            j_q      <= j_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Bench for bnn_layer_engine: table of layer commands against synchronous memory models,
// expected write-backs queued by a reference model and compared on every x_we.
module tb_bnn_layer_engine;

  localparam int WORD = 8, W_ADDR_LEN = 20, W_SEL_LEN = 2;
  localparam int X_ADDR_LEN = 10, X_SEL_LEN = 2, ACC_W = 16;
  localparam int SB_W = X_ADDR_LEN + WORD + X_SEL_LEN;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [X_ADDR_LEN-1:0] in_words = '0, n_out = '0;
  logic [ACC_W-1:0]      thresh = '0;
  logic [X_SEL_LEN-1:0]  src_sel = '0, dst_sel = '0;
  logic [W_SEL_LEN-1:0]  wbank = '0;
  logic                  busy, done, x_we;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic [W_SEL_LEN-1:0]  w_sel;
  logic [WORD-1:0]       w_data = '0, x_rdata = '0, x_wdata;
  logic [X_ADDR_LEN-1:0] x_addr;
  logic [X_SEL_LEN-1:0]  x_sel;
  logic [2:0]            dbg_state;

  bnn_layer_engine #(
    .WORD(WORD), .W_ADDR_LEN(W_ADDR_LEN), .W_SEL_LEN(W_SEL_LEN),
    .X_ADDR_LEN(X_ADDR_LEN), .X_SEL_LEN(X_SEL_LEN), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_words(in_words), .n_out(n_out),
    .thresh(thresh), .src_sel(src_sel), .dst_sel(dst_sel), .wbank(wbank),
    .busy(busy), .done(done), .w_addr(w_addr), .w_sel(w_sel), .w_data(w_data),
    .x_addr(x_addr), .x_sel(x_sel), .x_rdata(x_rdata), .x_wdata(x_wdata),
    .x_we(x_we), .dbg_state(dbg_state)
  );

  // clock / memory models
  always #5 clk = ~clk;

  logic [7:0] x_mem [4][16];
  logic [7:0] w_mem [64];

  always @(posedge clk) begin
    x_rdata <= x_mem[x_sel][x_addr[3:0]];
    w_data  <= w_mem[w_addr[5:0]];
  end

  // scoreboard and monitor
  int checks = 0, failures = 0;
  int busy_cyc = 0, done_cnt = 0, w_max = -1, w_first = -1;
  bit seen_busy = 0;
  logic [SB_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (!seen_busy) w_first = int'(w_addr);
        seen_busy = 1;
        busy_cyc++;
        if (int'(w_addr) > w_max) w_max = int'(w_addr);
      end
      if (done) done_cnt++;
      if (x_we) begin
        logic [SB_W-1:0] got, exp;
        got = {x_addr, x_wdata, x_sel};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected got addr=%0d data=%h sel=%0d", x_addr, x_wdata, x_sel);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL write_word got {addr,data,sel}=%h exp=%h", got, exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // reference model: pack thresholded XNOR-popcount results per output word
  task automatic push_expected(input int iw, input int no, input int th, input int src, input int dst);
    logic [7:0] word, xn;
    int m;
    word = '0;
    for (int j = 0; j < no; j++) begin
      m = 0;
      for (int k = 0; k < iw; k++) begin
        xn = ~(x_mem[src][k % 16] ^ w_mem[(j * iw + k) % 64]);
        m += $countones(xn);
      end
      word[j % 8] = (m >= th);
      if ((j % 8) == 7 || j == no - 1) begin
        exp_q.push_back({X_ADDR_LEN'(j / 8), word, X_SEL_LEN'(dst)});
        word = '0;
      end
    end
  endtask

  // drive one command; optionally pulse start again while busy with a different in_words
  task automatic run_cmd(input int iw, input int no, input int th, input int src,
                         input int dst, input int wb, input bit extra_start, output bit timed_out);
    @(posedge clk); #1;
    in_words = X_ADDR_LEN'(iw); n_out = X_ADDR_LEN'(no); thresh = ACC_W'(th);
    src_sel = X_SEL_LEN'(src); dst_sel = X_SEL_LEN'(dst); wbank = W_SEL_LEN'(wb);
    busy_cyc = 0; done_cnt = 0; w_max = -1; w_first = -1; seen_busy = 0;
    if (iw != 0 && no != 0) push_expected(iw, no, th, src, dst);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; in_words = X_ADDR_LEN'(7);
      @(posedge clk); #1; start = 1'b0;
    end
    timed_out = 1;
    for (int c = 0; c < 500; c++) begin
      if (done_cnt != 0) begin
        timed_out = 0;
        break;
      end
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int iw, no, th;
    logic [7:0] xv, wv;
    int src, dst, wb;
    bit pat, xs;
    int cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit to;
    int w_pre;
    vecs[0] = '{iw:2, no:3,  th:8,  xv:8'hFF, wv:8'hFF, src:0, dst:1, wb:0, pat:0, xs:0, cyc:11};
    vecs[1] = '{iw:2, no:3,  th:8,  xv:8'hFF, wv:8'h00, src:0, dst:1, wb:1, pat:0, xs:0, cyc:11};
    vecs[2] = '{iw:1, no:10, th:8,  xv:8'hFF, wv:8'hFF, src:2, dst:3, wb:0, pat:0, xs:0, cyc:23};
    vecs[3] = '{iw:1, no:1,  th:4,  xv:8'hF0, wv:8'h00, src:1, dst:0, wb:2, pat:0, xs:0, cyc:4};
    vecs[4] = '{iw:1, no:1,  th:5,  xv:8'hF0, wv:8'h00, src:1, dst:0, wb:2, pat:0, xs:0, cyc:4};
    vecs[5] = '{iw:3, no:9,  th:12, xv:8'h00, wv:8'h00, src:1, dst:2, wb:3, pat:1, xs:0, cyc:39};
    vecs[6] = '{iw:0, no:5,  th:1,  xv:8'hFF, wv:8'hFF, src:0, dst:1, wb:1, pat:0, xs:0, cyc:1};
    vecs[7] = '{iw:2, no:0,  th:1,  xv:8'hFF, wv:8'hFF, src:0, dst:1, wb:1, pat:0, xs:0, cyc:1};
    vecs[8] = '{iw:2, no:8,  th:0,  xv:8'h00, wv:8'h00, src:3, dst:0, wb:1, pat:1, xs:0, cyc:26};
    vecs[9] = '{iw:2, no:3,  th:8,  xv:8'hFF, wv:8'hFF, src:0, dst:1, wb:0, pat:0, xs:1, cyc:11};

    // reset block
    #12;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_we", x_we, 0);
    chk("reset_w_addr", int'(w_addr), 0); chk("reset_x_addr", int'(x_addr), 0);
    chk("reset_x_wdata", int'(x_wdata), 0); chk("reset_state", int'(dbg_state), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 16; a++)
          x_mem[b][a] = vecs[v].pat ? 8'($urandom_range(0, 255)) : (b == vecs[v].src ? vecs[v].xv : ~vecs[v].xv);
      for (int a = 0; a < 64; a++)
        w_mem[a] = vecs[v].pat ? 8'($urandom_range(0, 255)) : vecs[v].wv;
      w_pre = int'(w_addr);
      run_cmd(vecs[v].iw, vecs[v].no, vecs[v].th, vecs[v].src, vecs[v].dst, vecs[v].wb, vecs[v].xs, to);
      chk($sformatf("v%0d_timeout", v), int'(to), 0);
      chk($sformatf("v%0d_busy_cycles", v), busy_cyc, vecs[v].cyc);
      chk($sformatf("v%0d_done_count", v), done_cnt, 1);
      chk($sformatf("v%0d_writes_left", v), exp_q.size(), 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
      if (vecs[v].iw == 0 || vecs[v].no == 0) begin
        chk($sformatf("v%0d_w_addr_held", v), int'(w_addr), w_pre);
      end else begin
        chk($sformatf("v%0d_w_first", v), w_first, 0);
        chk($sformatf("v%0d_w_max", v), w_max, vecs[v].iw * vecs[v].no - 1);
        chk($sformatf("v%0d_w_sel", v), int'(w_sel), vecs[v].wb);
      end
      exp_q.delete();
    end

    // asynchronous reset during neuron 1 of a layer, then a clean rerun
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) x_mem[b][a] = 8'hFF;
    for (int a = 0; a < 64; a++) w_mem[a] = 8'hFF;
    @(posedge clk); #1;
    in_words = 2; n_out = 3; thresh = 8; src_sel = 1; dst_sel = 3; wbank = 2;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    to = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (w_addr == 2) begin
        to = 0;
        break;
      end
    end
    chk("rst_reach_neuron1", int'(to), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_we", x_we, 0);
    chk("rst_w_addr", int'(w_addr), 0); chk("rst_w_sel", int'(w_sel), 0);
    chk("rst_x_addr", int'(x_addr), 0); chk("rst_x_sel", int'(x_sel), 0);
    chk("rst_x_wdata", int'(x_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_cyc = 0; done_cnt = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_stays_idle", busy_cyc, 0);
    chk("rst_no_done", done_cnt, 0);
    run_cmd(2, 3, 8, 1, 3, 2, 0, to);
    chk("rerun_timeout", int'(to), 0);
    chk("rerun_busy_cycles", busy_cyc, 11);
    chk("rerun_w_first", w_first, 0);
    chk("rerun_w_max", w_max, 5);
    chk("rerun_writes_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
